ram_device: RTL and testbench
=============================

Name: ram_device

Overview:
Board-side RAM device sitting directly downstream of the motherboard bus controller. It consumes the controller's ram_ctrl, addr and data_out and produces ram_stat and data_in. It implements a 4-phase ctrl/stat handshake with a configurable number of wait cycles, backed by a single-port word-addressed memory array. It acts as the real target for the controller's RAM read/write states.

Parameters:
word_width, 32, width of ctrl, stat, addr and data words
addr_width, 10, index bits; depth = 2**addr_width words
wait_cycles, 2, extra cycles spent in ACCESS before commit (0 allowed)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  reset; asynchronous, active-high
ram_ctrl  input  word_width  command from controller; bit CTRL_READ, bit CTRL_WRITE; 0 = no request
ram_stat  output  word_width  registered status: STAT_IDLE, STAT_BUSY, STAT_DONE, STAT_ERR
addr  input  word_width  word address
wdata  input  word_width  write data (controller data_out)
rdata  output  word_width  registered read data (controller data_in)

Behaviour:
- Clock/reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, ram_stat=STAT_IDLE, rdata=0, cnt=0. Memory contents are not cleared.
- Reset mid-operation: the pending write is discarded if rst arrives before the commit edge. The device then returns to IDLE.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, edge where ram_ctrl != 0:
  - Latch op, addr and wdata.
  - cnt <= wait_cycles; ram_stat <= STAT_BUSY; go to ACCESS.
  - If both CTRL_READ and CTRL_WRITE are set, read wins (matches controller priority).
  - If neither bit is set: ram_stat <= STAT_ERR and go directly to DONE.
- ACCESS:
  - If cnt != 0: cnt <= cnt-1.
  - Else commit. For a write, mem[idx] <= latched wdata. For a read, rdata <= mem[idx].
  - On commit: ram_stat <= STAT_DONE; go to DONE.
- Latency: request sampled at edge N; ram_stat=STAT_DONE and rdata valid after edge N+1+wait_cycles.
- DONE:
  - ram_stat and rdata hold.
  - At the first edge with ram_ctrl == 0: ram_stat <= STAT_IDLE, go to IDLE. rdata keeps its value.
- ram_ctrl, addr and wdata changes during ACCESS are ignored because the request fields were latched.
- If ram_ctrl drops during ACCESS, the operation still completes and the device passes through DONE. It leaves DONE at the next edge where ram_ctrl == 0.
- Back-to-back requests: a new request is accepted only from IDLE, so there is at least one IDLE cycle between operations.
- Index: idx = latched addr[addr_width-1:0].
- Write during a read: impossible, because the port is single-port and one op is in flight at a time.

Optional Feature:
RAM_BOUNDS_CHECK_EN
- Defined: at accept time, if addr[word_width-1:addr_width] != 0, the request is flagged out-of-range. At commit, no write occurs, rdata <= 0 and ram_stat <= STAT_ERR (not STAT_DONE). Wait-cycle timing is unchanged.
- Undefined: upper address bits are ignored and the address wraps modulo depth.

Decomposition:
- Shared include (control_pins): CTRL_READ=32'h1, CTRL_WRITE=32'h2, STAT_IDLE=0, STAT_DONE=1, STAT_BUSY=2, STAT_ERR=4.
- Local constants RAM_IDLE/RAM_ACCESS/RAM_DONE go in the mobo state include, next to the controller's states.
- One sub-module, ram_array: synchronous single-port memory with ports clk, we, idx, wdata, rdata (read registered, 1 cycle). ram_device issues the array read at the last ACCESS cycle so that rdata is valid at commit.

Test Plan:
- Write, wait_cycles=2: ctrl=CTRL_WRITE, addr=5, wdata=32'hDEADBEEF at edge 0 -> stat BUSY after edge 0, DONE after edge 3. Dropping ctrl -> stat IDLE one edge later.
- Read-back: ctrl=CTRL_READ, addr=5 -> rdata=32'hDEADBEEF with stat DONE after edge N+3. Change addr to 6 during ACCESS -> rdata still 32'hDEADBEEF.
- Priority/illegal:
  - ctrl=32'h3 to addr 5 -> a read is performed and mem[5] is unchanged.
  - ctrl=32'h8 -> stat ERR after one edge; returns to IDLE after ctrl=0.
- Bounds:
  - With RAM_BOUNDS_CHECK_EN: write addr=32'h400 -> stat ERR and mem[0] unchanged.
  - Without it: the write lands in mem[0] and a read of addr 0 returns the value.
- Reset mid-ACCESS: assert rst asynchronously, between clock edges, in the cycle before the commit edge of a write of 32'h1234 to addr 7 -> stat=STAT_IDLE and rdata=0 immediately. A read of addr 7 returns its old contents.
- wait_cycles=0 plus hold: a read returns DONE after edge N+1. Holding ctrl for 10 cycles keeps stat at DONE and rdata stable.

Source files
------------

// File: rtl/ram_device_pkg.sv
// rtl/ram_device_pkg.sv - control/status pin encodings and RAM device state/op types
package ram_device_pkg;

    localparam logic [31:0] CTRL_READ  = 32'h1;
    localparam logic [31:0] CTRL_WRITE = 32'h2;

    localparam logic [31:0] STAT_IDLE = 32'h0;
    localparam logic [31:0] STAT_DONE = 32'h1;
    localparam logic [31:0] STAT_BUSY = 32'h2;
    localparam logic [31:0] STAT_ERR  = 32'h4;

    typedef enum logic [1:0] {
        RAM_IDLE   = 2'd0,
        RAM_ACCESS = 2'd1,
        RAM_DONE   = 2'd2
    } ram_state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } ram_op_t;

    // Read takes priority when both command bits are set, matching the controller.
    function automatic ram_op_t decode_op(input logic rd, input logic wr);
        if (rd)
            return OP_READ;
        else if (wr)
            return OP_WRITE;
        else
            return OP_NONE;
    endfunction

endpackage

// File: rtl/ram_device_if.sv
// rtl/ram_device_if.sv - ctrl/stat handshake and data bus between controller and RAM device
interface ram_device_if #(
    parameter int word_width = 32
);
    logic [word_width-1:0] ram_ctrl;
    logic [word_width-1:0] ram_stat;
    logic [word_width-1:0] addr;
    logic [word_width-1:0] wdata;
    logic [word_width-1:0] rdata;

    modport master (output ram_ctrl, addr, wdata, input ram_stat, rdata);
    modport slave  (input ram_ctrl, addr, wdata, output ram_stat, rdata);
endinterface

// File: rtl/ram_device_ram_array.sv
// rtl/ram_device_ram_array.sv - single-port word memory with one-cycle registered read
module ram_array #(
    parameter int word_width = 32,
    parameter int addr_width = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] idx,
    input  logic [word_width-1:0] wdata,
    output logic [word_width-1:0] rdata
);
    localparam int DEPTH = 2 ** addr_width;

    logic [word_width-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

// File: rtl/ram_device.sv
// rtl/ram_device.sv - RAM target with 4-phase ctrl/stat handshake and wait cycles
// Optional out-of-range address rejection when RAM_BOUNDS_CHECK_EN is defined.
module ram_device
    import ram_device_pkg::*;
#(
    parameter int word_width  = 32,
    parameter int addr_width  = 10,
    parameter int wait_cycles = 2
) (
    input  logic         clk,
    input  logic         rst,
    ram_device_if.slave  bus
);
    localparam int CNT_W = (wait_cycles > 1) ? $clog2(wait_cycles + 1) : 1;

    ram_state_t            state, state_d;
    ram_op_t               op_q, op_d;
    logic [addr_width-1:0] idx_q, idx_d;
    logic [word_width-1:0] wdata_q, wdata_d;
    logic [word_width-1:0] stat_q, stat_d;
    logic [word_width-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  oob_q, oob_d;
    logic                  we;
    logic [addr_width-1:0] arr_idx;
    logic [word_width-1:0] arr_rdata;

    // The array reads every cycle; steering the index from the live bus while idle
    // lets a zero-wait read have its data ready at the very next (commit) edge.
    assign arr_idx = (state == RAM_IDLE) ? bus.addr[addr_width-1:0] : idx_q;

    ram_array #(
        .word_width(word_width),
        .addr_width(addr_width)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .idx  (arr_idx),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    always_comb begin
        state_d = state;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        stat_d  = stat_q;
        rdata_d = rdata_q;
        cnt_d   = cnt;
        oob_d   = oob_q;
        we      = 1'b0;
        case (state)
            RAM_IDLE: begin
                if (bus.ram_ctrl != '0) begin
                    op_d    = decode_op(bus.ram_ctrl[0], bus.ram_ctrl[1]);
                    idx_d   = bus.addr[addr_width-1:0];
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_W'(wait_cycles);
`ifdef RAM_BOUNDS_CHECK_EN
                    oob_d   = |bus.addr[word_width-1:addr_width];
`else
                    oob_d   = 1'b0;
`endif
                    if (op_d == OP_NONE) begin
                        stat_d  = word_width'(STAT_ERR);
                        state_d = RAM_DONE;
                    end else begin
                        stat_d  = word_width'(STAT_BUSY);
                        state_d = RAM_ACCESS;
                    end
                end
            end
            RAM_ACCESS: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    state_d = RAM_DONE;
                    if (oob_q) begin
                        stat_d  = word_width'(STAT_ERR);
                        rdata_d = '0;
                    end else begin
                        stat_d = word_width'(STAT_DONE);
                        if (op_q == OP_WRITE)
                            we = 1'b1;
                        else
                            rdata_d = arr_rdata;
                    end
                end
            end
            RAM_DONE: begin
                if (bus.ram_ctrl == '0) begin
                    stat_d  = word_width'(STAT_IDLE);
                    state_d = RAM_IDLE;
                end
            end
            default: begin
                state_d = RAM_IDLE;
                stat_d  = word_width'(STAT_IDLE);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RAM_IDLE;
            op_q    <= OP_NONE;
            idx_q   <= '0;
            wdata_q <= '0;
            stat_q  <= word_width'(STAT_IDLE);
            rdata_q <= '0;
            cnt     <= '0;
            oob_q   <= 1'b0;
        end else begin
            state   <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            stat_q  <= stat_d;
            rdata_q <= rdata_d;
            cnt     <= cnt_d;
            oob_q   <= oob_d;
        end
    end

    assign bus.ram_stat = stat_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_ram_device.sv
// tb/tb_ram_device.sv - scoreboard bench for ram_device (wait_cycles 2 and 0 instances)
module tb_ram_device;
    import ram_device_pkg::*;

    typedef struct {
        logic [31:0] stat;
        logic [31:0] rdata;
        int          edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_device_if #(.word_width(32)) bus2 ();
    ram_device_if #(.word_width(32)) bus0 ();

    ram_device #(.word_width(32), .addr_width(10), .wait_cycles(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );
    ram_device #(.word_width(32), .addr_width(10), .wait_cycles(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    exp_t q2[$];
    exp_t q0[$];
    exp_t m2, m0;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] prev2 = 32'h0;
    logic [31:0] prev0 = 32'h0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic is_done(input logic [31:0] s);
        return (s == STAT_DONE) || (s == STAT_ERR);
    endfunction

    function automatic logic [31:0] get_stat(input int sel);
        return (sel == 0) ? bus0.ram_stat : bus2.ram_stat;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus0.rdata : bus2.rdata;
    endfunction

    task automatic drive(input int sel, input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.ram_ctrl = c; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus2.ram_ctrl = c; bus2.addr = a; bus2.wdata = d;
        end
    endtask

    // Completion monitors: a rising DONE/ERR pops the next expected response.
    always @(negedge clk) begin
        if (is_done(bus2.ram_stat) && !is_done(prev2)) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_done", bus2.ram_stat, STAT_IDLE);
            end else begin
                m2 = q2.pop_front();
                check("dut2_stat", bus2.ram_stat, m2.stat);
                check("dut2_rdata", bus2.rdata, m2.rdata);
                check("dut2_edge", cyc, m2.edge_no);
            end
        end
        prev2 = bus2.ram_stat;
    end

    always @(negedge clk) begin
        if (is_done(bus0.ram_stat) && !is_done(prev0)) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", bus0.ram_stat, STAT_IDLE);
            end else begin
                m0 = q0.pop_front();
                check("dut0_stat", bus0.ram_stat, m0.stat);
                check("dut0_rdata", bus0.rdata, m0.rdata);
                check("dut0_edge", cyc, m0.edge_no);
            end
        end
        prev0 = bus0.ram_stat;
    end

    task automatic op(input int sel, input string tag, input logic [31:0] c, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] alt, input logic [31:0] es,
                      input logic [31:0] er, input int hold);
        int   lat;
        int   k;
        exp_t e;
        lat = (c[1:0] == 2'b00) ? 0 : ((sel == 0) ? 1 : 3);
        e.stat    = es;
        e.rdata   = er;
        e.edge_no = cyc + 1 + lat;
        if (sel == 0) q0.push_back(e);
        else          q2.push_back(e);
        drive(sel, c, a, d);
        @(negedge clk);
        if (lat > 0) check({tag, "_busy"}, get_stat(sel), STAT_BUSY);
        drive(sel, c, alt, ~d);
        k = 0;
        while (!is_done(get_stat(sel)) && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (k >= 30) check({tag, "_timeout"}, get_stat(sel), es);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_stat"}, get_stat(sel), es);
            check({tag, "_hold_rdata"}, get_rdata(sel), er);
        end
        drive(sel, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, "_idle"}, get_stat(sel), STAT_IDLE);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0);
        drive(2, 32'h0, 32'h0, 32'h0);
        #12;
        check("reset_stat2", bus2.ram_stat, STAT_IDLE);
        check("reset_rdata2", bus2.rdata, 32'h0);
        check("reset_stat0", bus0.ram_stat, STAT_IDLE);
        check("reset_rdata0", bus0.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(2, "wr5",   CTRL_WRITE, 32'd5, 32'hDEADBEEF, 32'd5, STAT_DONE, 32'h0,        0);
        op(2, "wr6",   CTRL_WRITE, 32'd6, 32'h66666666, 32'd6, STAT_DONE, 32'h0,        0);
        op(2, "rd5",   CTRL_READ,  32'd5, 32'h0,        32'd6, STAT_DONE, 32'hDEADBEEF, 0);
        op(2, "rd6",   CTRL_READ,  32'd6, 32'h0,        32'd6, STAT_DONE, 32'h66666666, 0);
        op(2, "both",  32'h3,      32'd5, 32'h0BADF00D, 32'd5, STAT_DONE, 32'hDEADBEEF, 0);
        op(2, "rd5b",  CTRL_READ,  32'd5, 32'h0,        32'd5, STAT_DONE, 32'hDEADBEEF, 0);
        op(2, "illeg", 32'h8,      32'd5, 32'h0,        32'd5, STAT_ERR,  32'hDEADBEEF, 0);
        op(2, "wr0",   CTRL_WRITE, 32'd0, 32'h12340000, 32'd0, STAT_DONE, 32'hDEADBEEF, 0);
`ifdef RAM_BOUNDS_CHECK_EN
        op(2, "oob",   CTRL_WRITE, 32'h400, 32'hCAFEF00D, 32'h400, STAT_ERR, 32'h0, 0);
        op(2, "rd0",   CTRL_READ,  32'd0, 32'h0,        32'd0, STAT_DONE, 32'h12340000, 0);
`else
        op(2, "wrap",  CTRL_WRITE, 32'h400, 32'hCAFEF00D, 32'h400, STAT_DONE, 32'hDEADBEEF, 0);
        op(2, "rd0",   CTRL_READ,  32'd0, 32'h0,        32'd0, STAT_DONE, 32'hCAFEF00D, 0);
`endif
        op(2, "rd5c",  CTRL_READ,  32'd5, 32'h0,        32'd5, STAT_DONE, 32'hDEADBEEF, 0);
        op(2, "wr7",   CTRL_WRITE, 32'd7, 32'hAAAA0007, 32'd7, STAT_DONE, 32'hDEADBEEF, 0);

        // Reset lands between the last wait edge and the commit edge of a write.
        drive(2, CTRL_WRITE, 32'd7, 32'h00001234);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_stat", bus2.ram_stat, STAT_IDLE);
        check("rst_mid_rdata", bus2.rdata, 32'h0);
        drive(2, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(2, "rd7",   CTRL_READ,  32'd7, 32'h0,        32'd7, STAT_DONE, 32'hAAAA0007, 0);

        op(0, "z_wr3", CTRL_WRITE, 32'd3, 32'h55AA55AA, 32'd3, STAT_DONE, 32'h0,        0);
        op(0, "z_rd3", CTRL_READ,  32'd3, 32'h0,        32'd9, STAT_DONE, 32'h55AA55AA, 10);

        repeat (2) @(negedge clk);
        check("sb_drain2", q2.size(), 32'd0);
        check("sb_drain0", q0.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
